// File: rtl/mips_mem_pkg.sv
// Shared memory-stage definitions: store opcodes, the buffered store entry
// and the write-port FSM states.
package mips_mem_pkg;

  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } wr_state_t;

  // Word-aligned address presented to data memory.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_encode.sv
// Combinational store narrowing: places sb/sh/sw data onto big-endian byte
// lanes and flags misaligned or illegal stores.
module store_lane_encode
  import mips_mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // Lane placement and alignment check per opcode
  always_comb begin
    wdata      = 32'h0000_0000;
    be         = 4'b0000;
    misaligned = 1'b0;
    case (opcode)
      OP_SB: begin
        be    = 4'b1000 >> addr_lo;
        wdata = {4{data[7:0]}};
      end
      OP_SH: begin
        if (addr_lo[0]) begin
          misaligned = 1'b1;
        end else begin
          be    = addr_lo[1] ? 4'b0011 : 4'b1100;
          wdata = {2{data[15:0]}};
        end
      end
      OP_SW: begin
        if (addr_lo != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          be    = 4'b1111;
          wdata = data;
        end
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_lane_packer.sv
// Store buffer between the MEM stage and the data-memory write port: packs
// stores into lanes, queues them, and issues one req/ack write at a time.
module store_lane_packer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [5:0]  st_opcode,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misaligned,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t     fifo_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
  logic [CNT_W-1:0] count_r, count_next_s, remain_s;
  wr_state_t        state_r, state_next_s;

  logic             st_ready_r, st_misaligned_r, mem_req_r, buf_empty_r;
  logic [31:0]      mem_addr_r, mem_wdata_r;
  logic [3:0]       mem_be_r;

  logic             mem_req_d_s;
  logic [31:0]      mem_addr_d_s, mem_wdata_d_s;
  logic [3:0]       mem_be_d_s;

  logic [31:0]      enc_wdata_s;
  logic [3:0]       enc_be_s;
  logic             reject_s, accept_s, push_s, pop_s;
  store_entry_t     new_entry_s, head_next_s;

  store_lane_encode u_encode (
    .opcode     (st_opcode),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (enc_wdata_s),
    .be         (enc_be_s),
    .misaligned (reject_s)
  );

  assign accept_s      = st_valid && st_ready_r;
  assign push_s        = accept_s && !reject_s;
  assign pop_s         = (state_r == S_REQ) && mem_ack;
  assign new_entry_s   = '{addr: word_addr(st_addr), wdata: enc_wdata_s, be: enc_be_s};
  assign count_next_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
  assign remain_s      = count_r - CNT_W'(pop_s);
  assign rd_ptr_next_s = pop_s ? rd_ptr_r + PTR_W'(1'b1) : rd_ptr_r;

  // Head visible after this edge; bypass the incoming store when the queue drains
  always_comb begin
    if (remain_s == '0) begin
      head_next_s = new_entry_s;
    end else begin
      head_next_s = fifo_r[rd_ptr_next_s];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: a request is outstanding whenever the queue holds an entry
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_next_s = (count_next_s != '0) ? S_REQ : S_IDLE;
      S_REQ:   state_next_s = (count_next_s != '0) ? S_REQ : S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode for the registered memory-port signals
  always_comb begin
    mem_req_d_s   = 1'b0;
    mem_addr_d_s  = mem_addr_r;
    mem_wdata_d_s = mem_wdata_r;
    mem_be_d_s    = 4'b0000;
    case (state_next_s)
      S_REQ: begin
        mem_req_d_s   = 1'b1;
        mem_addr_d_s  = head_next_s.addr;
        mem_wdata_d_s = head_next_s.wdata;
        mem_be_d_s    = head_next_s.be;
      end
      S_IDLE: begin
        mem_req_d_s = 1'b0;
      end
      default: begin
        mem_req_d_s = 1'b0;
      end
    endcase
  end

  // Queue storage; contents are don't-care outside the count window
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= new_entry_s;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_ready_r      <= 1'b1;
      st_misaligned_r <= 1'b0;
      buf_empty_r     <= 1'b1;
      mem_req_r       <= 1'b0;
      mem_addr_r      <= 32'h0000_0000;
      mem_wdata_r     <= 32'h0000_0000;
      mem_be_r        <= 4'b0000;
    end else begin
      st_ready_r      <= (count_next_s != CNT_W'(DEPTH));
      st_misaligned_r <= accept_s && reject_s;
      buf_empty_r     <= (count_next_s == '0) && !mem_req_d_s;
      mem_req_r       <= mem_req_d_s;
      mem_addr_r      <= mem_addr_d_s;
      mem_wdata_r     <= mem_wdata_d_s;
      mem_be_r        <= mem_be_d_s;
    end
  end

  assign st_ready      = st_ready_r;
  assign st_misaligned = st_misaligned_r;
  assign buf_empty     = buf_empty_r;
  assign mem_req       = mem_req_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_be        = mem_be_r;

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed self-checking bench for store_lane_packer (DEPTH=2).
module tb_store_lane_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [5:0]  st_opcode;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misaligned;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        buf_empty;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;

  store_lane_packer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_opcode(st_opcode),
    .st_addr(st_addr), .st_data(st_data), .st_misaligned(st_misaligned),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    st_valid  = v;
    st_opcode = op;
    st_addr   = a;
    st_data   = d;
  endtask

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    drive(1'b0, SB, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_mis", {31'b0, st_misaligned}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_empty", {31'b0, buf_empty}, 32'd1);
    rst = 1'b0;

    // sb with ack already high
    drive(1'b1, SB, 32'h0000_1003, 32'h0000_00AB);
    mem_ack = 1'b1;
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("sb_req", {31'b0, mem_req}, 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_be", {28'b0, mem_be}, 32'h1);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_empty", {31'b0, buf_empty}, 32'd0);
    tick();
    mem_ack = 1'b0;
    chk("sb_done_req", {31'b0, mem_req}, 32'd0);
    chk("sb_done_be", {28'b0, mem_be}, 32'h0);
    chk("sb_hold_addr", mem_addr, 32'h0000_1000);
    chk("sb_done_empty", {31'b0, buf_empty}, 32'd1);

    // sh then sw queued behind it
    drive(1'b1, SH, 32'h0000_2002, 32'hFFFF_1234);
    tick();
    chk("sh_addr", mem_addr, 32'h0000_2000);
    chk("sh_be", {28'b0, mem_be}, 32'h3);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    drive(1'b1, SW, 32'h0000_2000, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("sh_stable", mem_wdata, 32'h1234_1234);
    chk("two_full", {31'b0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("sw_be", {28'b0, mem_be}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_ready", {31'b0, st_ready}, 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("sw_done_req", {31'b0, mem_req}, 32'd0);
    chk("sw_done_empty", {31'b0, buf_empty}, 32'd1);

    // rejects: misaligned sh and illegal opcode
    drive(1'b1, SH, 32'h0000_3001, 32'h5555_5555);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("mis_sh_pulse", {31'b0, st_misaligned}, 32'd1);
    chk("mis_sh_req", {31'b0, mem_req}, 32'd0);
    chk("mis_sh_empty", {31'b0, buf_empty}, 32'd1);
    tick();
    chk("mis_sh_end", {31'b0, st_misaligned}, 32'd0);
    chk("mis_sh_req2", {31'b0, mem_req}, 32'd0);
    drive(1'b1, 6'b100011, 32'h0000_3000, 32'h6666_6666);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("ill_pulse", {31'b0, st_misaligned}, 32'd1);
    chk("ill_req", {31'b0, mem_req}, 32'd0);
    chk("ill_empty", {31'b0, buf_empty}, 32'd1);
    tick();
    chk("ill_end", {31'b0, st_misaligned}, 32'd0);

    // back-pressure with ack held low
    drive(1'b1, SW, 32'h0000_4000, 32'h1111_1111);
    tick();
    chk("bp1_ready", {31'b0, st_ready}, 32'd1);
    chk("bp1_addr", mem_addr, 32'h0000_4000);
    drive(1'b1, SW, 32'h0000_4004, 32'h2222_2222);
    tick();
    chk("bp2_ready", {31'b0, st_ready}, 32'd0);
    drive(1'b1, SW, 32'h0000_4008, 32'h3333_3333);
    tick();
    chk("bp3_ready", {31'b0, st_ready}, 32'd0);
    chk("bp3_hold_addr", mem_addr, 32'h0000_4000);
    tick();
    chk("bp4_hold_wdata", mem_wdata, 32'h1111_1111);
    chk("bp4_req", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    tick();
    chk("bp_w2_addr", mem_addr, 32'h0000_4004);
    chk("bp_w2_wdata", mem_wdata, 32'h2222_2222);
    chk("bp_w2_ready", {31'b0, st_ready}, 32'd1);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("bp_w3_addr", mem_addr, 32'h0000_4008);
    chk("bp_w3_wdata", mem_wdata, 32'h3333_3333);
    tick();
    mem_ack = 1'b0;
    chk("bp_done", {31'b0, buf_empty}, 32'd1);

    // streaming accept+pop at count=1 across pointer wrap
    drive(1'b1, SW, 32'h0000_5000, 32'hC0DE_0000);
    tick();
    chk("wrap0_addr", mem_addr, 32'h0000_5000);
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, SW, 32'h0000_5000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      mem_ack = 1'b1;
      tick();
      chk("wrap_addr", mem_addr, 32'h0000_5000 + 32'(4 * i));
      chk("wrap_wdata", mem_wdata, 32'hC0DE_0000 + 32'(i));
      chk("wrap_ready", {31'b0, st_ready}, 32'd1);
    end
    drive(1'b0, SB, 32'h0, 32'h0);
    tick();
    mem_ack = 1'b0;
    chk("wrap_done", {31'b0, buf_empty}, 32'd1);

    // reset while two entries are pending
    drive(1'b1, SW, 32'h0000_7000, 32'h7777_7777);
    tick();
    drive(1'b1, SW, 32'h0000_7004, 32'h8888_8888);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, mem_req}, 32'd0);
    chk("arst_empty", {31'b0, buf_empty}, 32'd1);
    chk("arst_ready", {31'b0, st_ready}, 32'd1);
    rst = 1'b0;
    drive(1'b1, SB, 32'h0000_6001, 32'h0000_005A);
    tick();
    drive(1'b0, SB, 32'h0, 32'h0);
    chk("post_rst_addr", mem_addr, 32'h0000_6000);
    chk("post_rst_be", {28'b0, mem_be}, 32'h4);
    chk("post_rst_wdata", mem_wdata, 32'h5A5A_5A5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("post_rst_done", {31'b0, buf_empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
